// File: rtl/beacon_pkg.sv
// Shared types for the beacon detector: band codes, FSM states and
// the watchdog counter width.
package beacon_pkg;

  localparam int unsigned WD_WIDTH = 24;

  typedef enum logic [1:0] {
    BAND_NONE = 2'd0,
    BAND_A    = 2'd1,
    BAND_B    = 2'd2
  } band_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_LOCKED
  } state_e;

endpackage

// File: rtl/beacon_watchdog.sv
// Saturating loss-of-signal counter. It is cleared by kick and
// otherwise counts up to TIMEOUT_CYCLES.
module beacon_watchdog
  import beacon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic expired
);

  localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] ONE   = WD_WIDTH'(1);

  logic [WD_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Expiry fires on the edge at which the count reaches LIMIT, and it stays
  // asserted while saturated. A same-cycle kick always takes precedence.
  assign expired = !kick && (cnt_q >= LIMIT - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/beacon_detector.sv
// Classifies measured periods into beacon bands, then debounces them into a
// locked band code. A watchdog flags signal loss.
module beacon_detector
  import beacon_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BAND_A_MIN     = 9500,
  parameter int unsigned BAND_A_MAX     = 10500,
  parameter int unsigned BAND_B_MIN     = 950,
  parameter int unsigned BAND_B_MAX     = 1050,
  parameter int unsigned CONFIRM        = 4,
  parameter int unsigned MISS_LIMIT     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] period,
  input  logic             period_valid,
  output logic [1:0]       band,
  output logic             locked,
  output logic             lock_pulse,
  output logic             signal_lost
);

  localparam logic [3:0] CONFIRM_N = 4'(CONFIRM);
  localparam logic [3:0] MISS_N    = 4'(MISS_LIMIT);

  state_e     state_q, state_d;
  band_e      cand_q, cand_d;
  band_e      band_q, band_d;
  band_e      cls;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       locked_q, locked_d;
  logic       lock_pulse_q, lock_pulse_d;
  logic       signal_lost_q, signal_lost_d;
  logic       wd_expired;

  beacon_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .kick   (period_valid),
    .expired(wd_expired)
  );

  // Band A is checked first so that it wins on overlapping bounds.
  always_comb begin
    cls = BAND_NONE;
    if (period != '0) begin
      if (period >= WIDTH'(BAND_A_MIN) && period <= WIDTH'(BAND_A_MAX)) begin
        cls = BAND_A;
      end else if (period >= WIDTH'(BAND_B_MIN) && period <= WIDTH'(BAND_B_MAX)) begin
        cls = BAND_B;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    band_d        = band_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    locked_d      = locked_q;
    lock_pulse_d  = 1'b0;
    signal_lost_d = signal_lost_q;

    if (wd_expired) begin
      state_d       = ST_IDLE;
      cand_d        = BAND_NONE;
      band_d        = BAND_NONE;
      match_cnt_d   = '0;
      miss_cnt_d    = '0;
      locked_d      = 1'b0;
      signal_lost_d = 1'b1;
    end else if (period_valid) begin
      signal_lost_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cls != BAND_NONE) begin
            cand_d      = cls;
            match_cnt_d = 4'd1;
            state_d     = ST_CONFIRM;
            if (CONFIRM_N == 4'd1) begin
              state_d      = ST_LOCKED;
              match_cnt_d  = '0;
              miss_cnt_d   = '0;
              band_d       = cls;
              locked_d     = 1'b1;
              lock_pulse_d = 1'b1;
            end
          end
        end
        ST_CONFIRM: begin
          if (cls == BAND_NONE) begin
            state_d     = ST_IDLE;
            cand_d      = BAND_NONE;
            match_cnt_d = '0;
          end else if (cls != cand_q) begin
            cand_d      = cls;
            match_cnt_d = 4'd1;
          end else if (match_cnt_q + 4'd1 == CONFIRM_N) begin
            state_d      = ST_LOCKED;
            match_cnt_d  = '0;
            miss_cnt_d   = '0;
            band_d       = cand_q;
            locked_d     = 1'b1;
            lock_pulse_d = 1'b1;
          end else begin
            match_cnt_d = match_cnt_q + 4'd1;
          end
        end
        ST_LOCKED: begin
          if (cls == cand_q) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q + 4'd1 == MISS_N) begin
            state_d    = ST_IDLE;
            cand_d     = BAND_NONE;
            miss_cnt_d = '0;
            band_d     = BAND_NONE;
            locked_d   = 1'b0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cand_q        <= BAND_NONE;
      band_q        <= BAND_NONE;
      match_cnt_q   <= '0;
      miss_cnt_q    <= '0;
      locked_q      <= 1'b0;
      lock_pulse_q  <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      band_q        <= band_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      locked_q      <= locked_d;
      lock_pulse_q  <= lock_pulse_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign band        = band_q;
  assign locked      = locked_q;
  assign lock_pulse  = lock_pulse_q;
  assign signal_lost = signal_lost_q;

endmodule
